mac_v2_ctrl: RTL
================

# mac_v2_ctrl

Tile scheduler for the 2x2 systolic MAC (`mac_v2`). It walks every BLOCK_SIZE x BLOCK_SIZE output tile of C = A x B and drives the MAC's `en` and `reset_acc`. It generates read addresses into the A and B tile buffers and presents each finished tile to the writeback stage through a valid/ready handshake. It sits between the top-level matrix-multiply FSM (start/done) and one `mac_v2` instance.

## Interface
- ROW_A, 4: rows of A; multiple of BLOCK_SIZE.
- INNER_DIMENSION, 64: columns of A / rows of B; multiple of BLOCK_SIZE.
- COL_B, 4: columns of B; multiple of BLOCK_SIZE.
- BLOCK_SIZE, 2: systolic dimension.
- ADDR_WIDTH_A, 8: A buffer address width; must hold NUM_I*NUM_K-1.
- ADDR_WIDTH_B, 8: B buffer address width; must hold NUM_J*NUM_K-1.
- ADDR_WIDTH_OUT, 8: output tile index width; must hold NUM_I*NUM_J-1.
- Derived values: NUM_I=ROW_A/BLOCK_SIZE, NUM_K=INNER_DIMENSION/BLOCK_SIZE, NUM_J=COL_B/BLOCK_SIZE.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one full multiply; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last tile handshake.
- err_seq  out  1  sticky sequencing error; cleared by an accepted start.
- mac_en  out  1  to `mac_v2.en`.
- mac_reset_acc  out  1  to `mac_v2.reset_acc`; active-low accumulator clear.
- systolic_finish  in  1  from the MAC; one chunk consumed.
- accumulator_done  in  1  from the MAC; tile sum complete.
- addr_a  out  ADDR_WIDTH_A  A tile address = i*NUM_K + k.
- addr_b  out  ADDR_WIDTH_B  B tile address = j*NUM_K + k.
- out_valid  out  1  tile result on `out_mac` is valid.
- out_ready  in  1  writeback accepts the tile.
- out_addr  out  ADDR_WIDTH_OUT  tile index = i*NUM_J + j.

## Operation
- Counters: i in 0..NUM_I-1 (outer), j in 0..NUM_J-1 (middle), k in 0..NUM_K-1 (inner). All outputs are registered.
- States: IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE.
- IDLE: mac_en=0, mac_reset_acc=0, counters held at 0. On start=1: clear err_seq, go to CLEAR.
- CLEAR: exactly 1 cycle with mac_reset_acc=0, k=0. Next state is FEED.
- FEED: mac_en=1, mac_reset_acc=1, addresses reflect the current i, j, k.
  - On systolic_finish with k<NUM_K-1: k++.
  - On systolic_finish with k=NUM_K-1: go to DRAIN, or directly to OUTPUT if accumulator_done is also high that cycle.
- DRAIN: mac_en=0, mac_reset_acc=1. Wait for accumulator_done, then go to OUTPUT.
- OUTPUT: out_valid=1, out_addr stable, mac_en=0. Wait for out_valid & out_ready, then:
  - If this is the last tile (i=NUM_I-1, j=NUM_J-1): go to DONE.
  - Otherwise: j++; if j wraps to 0, i++. Go to CLEAR.
- DONE: done=1 for 1 cycle, counters reset to 0, then go to IDLE.
- Sequencing errors set err_seq but do not change the state transitions:
  - accumulator_done in FEED before the last chunk's systolic_finish.
  - systolic_finish in DRAIN or OUTPUT.
- start outside IDLE is ignored.
- Reset (any time, including mid-tile): state=IDLE; i=j=k=0; mac_en=0, mac_reset_acc=0, busy=0, done=0, err_seq=0, out_valid=0, addr_a=0, addr_b=0, out_addr=0.

## Timing
- start sampled high in IDLE at edge T → CLEAR in cycle T+1 → FEED from T+2, with mac_en=1 and addr_a/addr_b valid in that same cycle.
- Addresses change 1 cycle after the systolic_finish that advances k.
- OUTPUT is entered 1 cycle after accumulator_done. out_valid stays high and out_addr stays stable until the handshake cycle; out_valid drops the next cycle.
- Minimum tile period = 1 (CLEAR) + FEED cycles + DRAIN cycles + 1 (OUTPUT, if out_ready is already high).
- done pulses 1 cycle after the final handshake. busy falls in the cycle after done.
- Back-to-back start: a start asserted in the cycle after done (IDLE) is accepted.

## Test plan
- Basic sweep: ROW_A=INNER_DIMENSION=COL_B=4, out_ready=1, MAC model pulses systolic_finish every 3 cycles and accumulator_done 2 cycles after the last finish. Required response:
  - out_addr sequence 0,1,2,3.
  - addr_a sequence per tile (0,1),(0,1),(2,3),(2,3).
  - addr_b sequence per tile (0,1),(2,3),(0,1),(2,3).
  - done pulses once and err_seq stays 0.
- Backpressure: hold out_ready=0 for 5 cycles on tile 1 → out_valid and out_addr=1 stable for 6 cycles; mac_en=0 throughout; no address change.
- Simultaneous finish and done: last systolic_finish coincides with accumulator_done → FEED goes directly to OUTPUT with no DRAIN cycle.
- Early accumulator_done at k=0 → err_seq=1 and remains set. The tile still completes normally. The next accepted start clears err_seq.
- Reset mid-FEED at tile 2, k=1 → all outputs return to reset values immediately. A new start restarts at out_addr=0, addr_a=0, addr_b=0.
- start pulsed while busy → ignored; the tile sequence is unchanged and done pulses exactly once.

Source files
------------

// File: rtl/mac_v2_ctrl_if.sv
// Bundle between the tile scheduler and its surroundings: the start/done
// handshake with the top-level FSM, the enable/clear/status lines of one
// mac_v2 instance, the A/B tile-buffer read addresses and the valid/ready
// handshake towards writeback.
//   slave  : the scheduler (mac_v2_ctrl) side
//   master : the environment side (top FSM, MAC, buffers, writeback)
interface mac_v2_ctrl_if #(
  parameter int unsigned ADDR_WIDTH_A   = 8,
  parameter int unsigned ADDR_WIDTH_B   = 8,
  parameter int unsigned ADDR_WIDTH_OUT = 8
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      err_seq;
  logic                      mac_en;
  logic                      mac_reset_acc;
  logic                      systolic_finish;
  logic                      accumulator_done;
  logic [ADDR_WIDTH_A-1:0]   addr_a;
  logic [ADDR_WIDTH_B-1:0]   addr_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [ADDR_WIDTH_OUT-1:0] out_addr;

  modport slave (
    input  start, systolic_finish, accumulator_done, out_ready,
    output busy, done, err_seq, mac_en, mac_reset_acc,
           addr_a, addr_b, out_valid, out_addr
  );

  modport master (
    output start, systolic_finish, accumulator_done, out_ready,
    input  busy, done, err_seq, mac_en, mac_reset_acc,
           addr_a, addr_b, out_valid, out_addr
  );
endinterface

// File: rtl/mac_v2_ctrl.sv
// Tile scheduler for the 2x2 systolic MAC (mac_v2).
// Walks every BLOCK_SIZE x BLOCK_SIZE output tile of C = A x B (i outer,
// j middle, k inner), drives mac_en / mac_reset_acc (active-low clear),
// generates A/B tile-buffer addresses and hands each finished tile to
// writeback through out_valid/out_ready.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mac_v2_ctrl_if.slave (start, busy, done, err_seq, mac_en,
//          mac_reset_acc, systolic_finish, accumulator_done, addr_a,
//          addr_b, out_valid, out_ready, out_addr)
module mac_v2_ctrl #(
  parameter int unsigned ROW_A           = 4,
  parameter int unsigned INNER_DIMENSION = 64,
  parameter int unsigned COL_B           = 4,
  parameter int unsigned BLOCK_SIZE      = 2,
  parameter int unsigned ADDR_WIDTH_A    = 8,
  parameter int unsigned ADDR_WIDTH_B    = 8,
  parameter int unsigned ADDR_WIDTH_OUT  = 8
) (
  input logic          clk,
  input logic          rst,
  mac_v2_ctrl_if.slave bus
);

  localparam int unsigned NUM_I = ROW_A / BLOCK_SIZE;
  localparam int unsigned NUM_K = INNER_DIMENSION / BLOCK_SIZE;
  localparam int unsigned NUM_J = COL_B / BLOCK_SIZE;

  localparam int unsigned IW = (NUM_I > 1) ? $clog2(NUM_I) : 1;
  localparam int unsigned KW = (NUM_K > 1) ? $clog2(NUM_K) : 1;
  localparam int unsigned JW = (NUM_J > 1) ? $clog2(NUM_J) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(NUM_I - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_K - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NUM_J - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    OUTPUT,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0] i_q, i_d;
  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;
  logic          err_q, err_d;

  logic                      mac_en_q;
  logic                      mac_reset_acc_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      out_valid_q;
  logic [ADDR_WIDTH_A-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_WIDTH_B-1:0]   addr_b_q, addr_b_d;
  logic [ADDR_WIDTH_OUT-1:0] out_addr_q, out_addr_d;

  logic last_chunk;
  logic last_tile;

  assign last_chunk = (k_q == K_LAST);
  assign last_tile  = (i_q == I_LAST) && (j_q == J_LAST);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        if (bus.start) begin
          err_d   = 1'b0;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        k_d     = '0;
        state_d = FEED;
      end

      FEED: begin
        // accumulator_done is only legal together with the last chunk's finish
        if (bus.accumulator_done && !(bus.systolic_finish && last_chunk)) begin
          err_d = 1'b1;
        end
        if (bus.systolic_finish) begin
          if (last_chunk) begin
            state_d = bus.accumulator_done ? OUTPUT : DRAIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (bus.systolic_finish) begin
          err_d = 1'b1;
        end
        if (bus.accumulator_done) begin
          state_d = OUTPUT;
        end
      end

      OUTPUT: begin
        if (bus.systolic_finish) begin
          err_d = 1'b1;
        end
        // out_valid is high throughout OUTPUT, so out_ready alone completes it
        if (bus.out_ready) begin
          if (last_tile) begin
            state_d = DONE;
          end else begin
            state_d = CLEAR;
            if (j_q == J_LAST) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end

      DONE: begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    addr_a_d   = ADDR_WIDTH_A'(32'(i_d) * NUM_K + 32'(k_d));
    addr_b_d   = ADDR_WIDTH_B'(32'(j_d) * NUM_K + 32'(k_d));
    out_addr_d = ADDR_WIDTH_OUT'(32'(i_d) * NUM_J + 32'(j_d));
  end

  // Outputs are registered from the next-state values so each one is
  // aligned with the state it belongs to, without a decode after the flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      i_q             <= '0;
      j_q             <= '0;
      k_q             <= '0;
      err_q           <= 1'b0;
      mac_en_q        <= 1'b0;
      mac_reset_acc_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      addr_a_q        <= '0;
      addr_b_q        <= '0;
      out_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      i_q             <= i_d;
      j_q             <= j_d;
      k_q             <= k_d;
      err_q           <= err_d;
      mac_en_q        <= (state_d == FEED);
      mac_reset_acc_q <= (state_d == FEED) || (state_d == DRAIN) || (state_d == OUTPUT);
      busy_q          <= (state_d != IDLE);
      done_q          <= (state_d == DONE);
      out_valid_q     <= (state_d == OUTPUT);
      addr_a_q        <= addr_a_d;
      addr_b_q        <= addr_b_d;
      out_addr_q      <= out_addr_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_seq       = err_q;
  assign bus.mac_en        = mac_en_q;
  assign bus.mac_reset_acc = mac_reset_acc_q;
  assign bus.addr_a        = addr_a_q;
  assign bus.addr_b        = addr_b_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_addr      = out_addr_q;

endmodule
